// File: rtl/psw_reg_if.sv
// Bus bundle for the processor status word register: flag writes, exception
// entry/return, wake request and the registered status outputs.
interface psw_reg_if;
   logic [15:0] psw_in;
   logic [15:0] psw_msk;
   logic        wr_en;
   logic        exc_entry;
   logic [2:0]  exc_pri;
   logic        exc_return;
   logic        irq_pending;
   logic [3:0]  cond_code;
   logic [15:0] psw;
   logic        cond_true;
   logic        sleep;
   logic        stk_fault;

   modport master (
      output psw_in, psw_msk, wr_en, exc_entry, exc_pri, exc_return,
             irq_pending, cond_code,
      input  psw, cond_true, sleep, stk_fault
   );

   modport slave (
      input  psw_in, psw_msk, wr_en, exc_entry, exc_pri, exc_return,
             irq_pending, cond_code,
      output psw, cond_true, sleep, stk_fault
   );
endinterface

// File: rtl/psw_reg.sv
// Processor status word with exception shadow store, condition evaluation and sleep control.
// PSW_SHADOW_STACK_EN selects a 4-deep shadow LIFO; otherwise a single shadow register.
//
// state  | meaning
// AWAKE  | core running; sleeps once SLP=1 with no interrupt pending
// ASLEEP | sleep asserted; leaves on irq_pending (clears SLP) or exc_entry
module psw_reg (
   input  logic     clk,
   input  logic     rst,
   psw_reg_if.slave bus
);
   typedef enum logic {AWAKE = 1'b0, ASLEEP = 1'b1} slp_state_e;

   localparam logic [15:0] PSW_RST   = 16'h00E0;
   localparam logic [15:0] PSW_WMASK = 16'hE1FF;

   logic [15:0] psw_q, psw_d;
   slp_state_e  state_q, state_d;
   logic        fault_q, fault_d;
   logic        push, pop;
   logic        stk_full, stk_empty;
   logic [15:0] stk_top;

   assign push = bus.exc_entry && !stk_full;
   assign pop  = !bus.exc_entry && bus.exc_return && !stk_empty;

`ifdef PSW_SHADOW_STACK_EN
   logic [15:0] stk_q [4];
   logic [2:0]  cnt_q;
   logic [2:0]  cnt_m1;

   assign cnt_m1    = cnt_q - 3'd1;
   assign stk_full  = (cnt_q == 3'd4);
   assign stk_empty = (cnt_q == 3'd0);
   assign stk_top   = stk_q[cnt_m1[1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 3'd0;
      end else if (push) begin
         cnt_q <= cnt_q + 3'd1;
      end else if (pop) begin
         cnt_q <= cnt_m1;
      end
   end

   // Entry data needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         stk_q[cnt_q[1:0]] <= psw_q;
      end
   end
`else
   logic [15:0] shd_q;
   logic        shd_vld_q;

   assign stk_full  = shd_vld_q;
   assign stk_empty = !shd_vld_q;
   assign stk_top   = shd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         shd_vld_q <= 1'b0;
      end else if (push) begin
         shd_vld_q <= 1'b1;
      end else if (pop) begin
         shd_vld_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         shd_q <= psw_q;
      end
   end
`endif

   always_comb begin
      psw_d   = psw_q;
      state_d = state_q;
      fault_d = fault_q;

      if (bus.exc_entry) begin
         psw_d[4:0]   = 5'b0_0000;
         psw_d[15:13] = psw_q[7:5];
         psw_d[7:5]   = bus.exc_pri;
         if (stk_full) begin
            psw_d[8] = 1'b1;
            fault_d  = 1'b1;
         end
      end else if (bus.exc_return) begin
         if (stk_empty) begin
            psw_d[8] = 1'b1;
            fault_d  = 1'b1;
         end else begin
            psw_d = stk_top;
         end
      end else if (bus.wr_en) begin
         psw_d = ((psw_q & ~bus.psw_msk) | (bus.psw_in & bus.psw_msk)) & PSW_WMASK;
      end

      // Wake clears SLP on top of whatever the update above produced.
      case (state_q)
         AWAKE: begin
            if (psw_q[3] && !bus.irq_pending && !bus.exc_entry) begin
               state_d = ASLEEP;
            end
         end
         ASLEEP: begin
            if (bus.irq_pending) begin
               state_d  = AWAKE;
               psw_d[3] = 1'b0;
            end else if (bus.exc_entry) begin
               state_d = AWAKE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         psw_q   <= PSW_RST;
         state_q <= AWAKE;
         fault_q <= 1'b0;
      end else begin
         psw_q   <= psw_d;
         state_q <= state_d;
         fault_q <= fault_d;
      end
   end

   logic flg_c, flg_z, flg_n, flg_v;
   logic cond_d;

   assign flg_c = psw_q[0];
   assign flg_z = psw_q[1];
   assign flg_n = psw_q[2];
   assign flg_v = psw_q[4];

   always_comb begin
      cond_d = 1'b0;
      case (bus.cond_code)
         4'd0:  cond_d = flg_z;
         4'd1:  cond_d = !flg_z;
         4'd2:  cond_d = flg_c;
         4'd3:  cond_d = !flg_c;
         4'd4:  cond_d = flg_n;
         4'd5:  cond_d = !flg_n;
         4'd6:  cond_d = flg_v;
         4'd7:  cond_d = !flg_v;
         4'd8:  cond_d = flg_c && !flg_z;
         4'd9:  cond_d = !flg_c || flg_z;
         4'd10: cond_d = (flg_n == flg_v);
         4'd11: cond_d = (flg_n != flg_v);
         4'd12: cond_d = !flg_z && (flg_n == flg_v);
         4'd13: cond_d = flg_z || (flg_n != flg_v);
         4'd14: cond_d = 1'b1;
         4'd15: cond_d = 1'b0;
      endcase
   end

   assign bus.psw       = psw_q;
   assign bus.cond_true = cond_d;
   assign bus.sleep     = (state_q == ASLEEP);
   assign bus.stk_fault = fault_q;
endmodule

// File: tb/tb_psw_reg.sv
// Self-checking bench for psw_reg: directed scenarios followed by random traffic,
// compared each cycle against a queue-based model of the status word.
module tb_psw_reg;
`ifdef PSW_SHADOW_STACK_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   psw_reg_if bus_if ();

   psw_reg u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   always #5 clk = ~clk;

   logic [15:0] m_psw;
   logic [15:0] m_stk[$];
   logic        m_asleep;
   logic        m_fault;

   function automatic logic cond_model(input logic [3:0] code, input logic [15:0] p);
      logic c, z, n, v;
      c = p[0]; z = p[1]; n = p[2]; v = p[4];
      case (code)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c & !z;
         4'd9:  return !c | z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z & (n == v);
         4'd13: return z | (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Next-state of the model from the inputs currently applied.
   task automatic model_update();
      logic [15:0] nxt;
      if (rst) begin
         m_psw = 16'h00E0;
         m_stk.delete();
         m_asleep = 1'b0;
         m_fault  = 1'b0;
         return;
      end
      nxt = m_psw;
      if (bus_if.exc_entry) begin
         nxt = (m_psw & 16'h0100) | (16'(bus_if.exc_pri) << 5) | (((m_psw >> 5) & 16'h0007) << 13);
         if (m_stk.size() == DEPTH) begin
            nxt = nxt | 16'h0100;
            m_fault = 1'b1;
         end else begin
            m_stk.push_back(m_psw);
         end
      end else if (bus_if.exc_return) begin
         if (m_stk.size() == 0) begin
            nxt = m_psw | 16'h0100;
            m_fault = 1'b1;
         end else begin
            nxt = m_stk.pop_back();
         end
      end else if (bus_if.wr_en) begin
         nxt = ((m_psw & ~bus_if.psw_msk) | (bus_if.psw_in & bus_if.psw_msk)) & 16'hE1FF;
      end
      if (m_asleep) begin
         if (bus_if.irq_pending) begin
            m_asleep = 1'b0;
            nxt = nxt & ~16'h0008;
         end else if (bus_if.exc_entry) begin
            m_asleep = 1'b0;
         end
      end else if (m_psw[3] && !bus_if.irq_pending && !bus_if.exc_entry) begin
         m_asleep = 1'b1;
      end
      m_psw = nxt;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_psw"}, bus_if.psw, m_psw);
      chk({tag, "_cond"}, {15'b0, bus_if.cond_true}, {15'b0, cond_model(bus_if.cond_code, m_psw)});
      chk({tag, "_sleep"}, {15'b0, bus_if.sleep}, {15'b0, m_asleep});
      chk({tag, "_fault"}, {15'b0, bus_if.stk_fault}, {15'b0, m_fault});
   endtask

   task automatic step(input string tag);
      model_update();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      bus_if.psw_in      = '0;
      bus_if.psw_msk     = '0;
      bus_if.wr_en       = 1'b0;
      bus_if.exc_entry   = 1'b0;
      bus_if.exc_pri     = '0;
      bus_if.exc_return  = 1'b0;
      bus_if.irq_pending = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      bus_if.cond_code = 4'd8;
      m_psw = '0; m_asleep = 1'b0; m_fault = 1'b0;
      step("rst0");
      step("rst1");
      rst = 1'b0;
      chk("reset_psw", bus_if.psw, 16'h00E0);

      // Masked write; HI with C=1,Z=1 is false.
      bus_if.wr_en = 1'b1; bus_if.psw_in = 16'h001F; bus_if.psw_msk = 16'h0013;
      step("wr1");
      idle_inputs();
      chk("wr1_lit", bus_if.psw, 16'h00F3);
      chk("wr1_hi", {15'b0, bus_if.cond_true}, 16'h0000);

      // C=1 Z=0 N=1 V=0, then sweep every condition code.
      bus_if.wr_en = 1'b1; bus_if.psw_in = 16'h0005; bus_if.psw_msk = 16'h0017;
      step("wr2");
      idle_inputs();
      for (int i = 0; i < 16; i++) begin
         bus_if.cond_code = 4'(i);
         step("sweep");
         if (i == 10) chk("sweep_ge", {15'b0, bus_if.cond_true}, 16'h0000);
         if (i == 11) chk("sweep_lt", {15'b0, bus_if.cond_true}, 16'h0001);
      end

      // Entry beats a same-cycle write; return restores exactly.
      bus_if.exc_entry = 1'b1; bus_if.exc_pri = 3'd3;
      bus_if.wr_en = 1'b1; bus_if.psw_in = 16'hFFFF; bus_if.psw_msk = 16'hFFFF;
      step("entry");
      idle_inputs();
      chk("entry_lit", bus_if.psw, 16'hE060);
      bus_if.exc_return = 1'b1;
      step("ret");
      idle_inputs();
      chk("ret_lit", bus_if.psw, 16'h00E5);

      // Sleep entry and irq wake.
      bus_if.wr_en = 1'b1; bus_if.psw_in = 16'h0008; bus_if.psw_msk = 16'h0008;
      step("slp_wr");
      idle_inputs();
      chk("slp_not_yet", {15'b0, bus_if.sleep}, 16'h0000);
      step("slp_go");
      chk("slp_on", {15'b0, bus_if.sleep}, 16'h0001);
      bus_if.irq_pending = 1'b1;
      step("wake");
      idle_inputs();
      chk("wake_sleep", {15'b0, bus_if.sleep}, 16'h0000);
      chk("wake_slp_bit", {15'b0, bus_if.psw[3]}, 16'h0000);

      // Overflow the shadow store, then unwind it.
      rst = 1'b1; step("rst2"); rst = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         bus_if.exc_entry = 1'b1; bus_if.exc_pri = 3'(i);
         step("nest");
      end
      idle_inputs();
      chk("ovf_fault", {15'b0, bus_if.stk_fault}, 16'h0001);
      for (int i = 0; i < DEPTH; i++) begin
         bus_if.exc_return = 1'b1;
         step("unwind");
      end
      idle_inputs();
      chk("unwind_lit", bus_if.psw, 16'h00E0);

      // Pop on empty store.
      rst = 1'b1; step("rst3"); rst = 1'b0;
      bus_if.exc_return = 1'b1;
      step("udf");
      idle_inputs();
      chk("udf_psw", bus_if.psw, 16'h01E0);
      chk("udf_fault", {15'b0, bus_if.stk_fault}, 16'h0001);

      // Random traffic including mid-operation resets.
      for (int n = 0; n < 800; n++) begin
         rst                = ($urandom_range(0, 59) == 0);
         bus_if.exc_entry   = ($urandom_range(0, 7) == 0);
         bus_if.exc_return  = ($urandom_range(0, 6) == 0);
         bus_if.wr_en       = ($urandom_range(0, 2) == 0);
         bus_if.irq_pending = ($urandom_range(0, 5) == 0);
         bus_if.psw_in      = 16'($urandom);
         bus_if.psw_msk     = 16'($urandom);
         bus_if.exc_pri     = 3'($urandom_range(0, 7));
         bus_if.cond_code   = 4'($urandom_range(0, 15));
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/psw_reg.md
PSW_REG -- requirements
Module: psw_reg

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port psw_in  input  16  candidate PSW value from the flag-update logic.
REQ-004 SHALL have port psw_msk  input  16  per-bit write mask; 1 = take psw_in bit.
REQ-005 SHALL have port wr_en  input  1  qualifies the masked write this cycle.
REQ-006 SHALL have port exc_entry  input  1  exception entry pulse.
REQ-007 SHALL have port exc_pri  input  3  priority of the entering exception.
REQ-008 SHALL have port exc_return  input  1  exception return pulse.
REQ-009 SHALL have port irq_pending  input  1  any enabled interrupt pending.
REQ-010 SHALL have port cond_code  input  4  branch/CEX condition selector.
REQ-011 SHALL have port psw  output  16  current registered PSW.
REQ-012 SHALL have port cond_true  output  1  cond_code evaluated against registered psw.
REQ-013 SHALL have port sleep  output  1  core stall request.
REQ-014 SHALL have port stk_fault  output  1  sticky shadow-stack overflow/underflow flag.

Function
REQ-015 SHALL use the bit layout: C=0, Z=1, N=2, SLP=3, V=4, cur_pri=7:5, FLT=8, prv_pri=15:13; bits 12:9 read 0 and are never written.
REQ-016 SHALL, on wr_en, load psw <= (psw & ~psw_msk) | (psw_in & psw_msk) at the next edge; effect is visible on psw one cycle after wr_en, with no bypass.
REQ-017 SHALL, on exc_entry, push psw to the shadow store, then set prv_pri=cur_pri, cur_pri=exc_pri, SLP=0, C/Z/N/V=0, all at the same edge.
REQ-018 SHALL, on exc_return, pop the shadow store top into psw at the next edge.
REQ-019 SHALL apply same-cycle priority rst > exc_entry > exc_return > wr_en; a lower-priority request in the same cycle is discarded.
REQ-020 SHALL evaluate cond_true combinationally for codes 0-15 as: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, NV 0.
REQ-021 SHALL use a two-state sleep FSM: AWAKE -> ASLEEP when SLP=1 and irq_pending=0; ASLEEP -> AWAKE when irq_pending=1, clearing SLP at the same edge; sleep=1 only in ASLEEP.
REQ-022 SHALL, when exc_entry is seen in ASLEEP, return to AWAKE at the same edge.
REQ-023 SHALL, on push when full, drop the push, leave the stack unchanged, still apply the entry PSW changes, and set stk_fault and FLT.
REQ-024 SHALL, on pop when empty, leave psw unchanged and set stk_fault and FLT.
REQ-025 SHALL keep stk_fault sticky until rst; FLT remains writable through masked writes.

Reset
REQ-026 SHALL, on rst, drive psw=16'h00E0 (cur_pri=7, all other bits 0), empty the shadow store, enter AWAKE, and set sleep=0 and stk_fault=0.
REQ-027 SHALL, when rst is asserted mid-operation, discard every pending write, push and pop in that cycle.
REQ-028 SHALL make cond_true reflect the reset psw in the first cycle after reset.

Configuration
REQ-029 SHALL, with PSW_SHADOW_STACK_EN defined, implement the shadow store as a 4-entry LIFO with a 3-bit occupancy count (0-4), allowing 4 nested exceptions; the 5th push sets the fault.
REQ-030 SHALL, without PSW_SHADOW_STACK_EN, implement the shadow store as a single register with a valid bit; a second push while valid sets the fault; no other behaviour changes.

Verification
REQ-031 SHALL cover: reset, then wr_en with psw_in=16'h001F, psw_msk=16'h0013 -> psw=16'h00F3 next cycle and cond_code=HI gives cond_true=0.
REQ-032 SHALL cover: psw C=1, Z=0, N=1, V=0, then sweep all 16 cond_code values -> cond_true matches REQ-020 table, with GE=0 and LT=1.
REQ-033 SHALL cover: exc_entry with exc_pri=3 and wr_en in the same cycle -> write ignored, cur_pri=3, prv_pri=7; then exc_return -> psw restored bit-exact.
REQ-034 SHALL cover: set SLP with irq_pending=0 -> sleep=1 on the following cycle; then pulse irq_pending -> sleep=0 and SLP=0 one edge later.
REQ-035 SHALL cover: with the macro, 5 exc_entry pulses -> stk_fault=1 after the 5th and the 4 pops restore correctly; without the macro, 2 pulses -> stk_fault=1.
REQ-036 SHALL cover: exc_return on an empty stack -> psw unchanged except FLT=1, and stk_fault=1.
